spi_cmd_decoder: RTL and testbench
==================================

# spi_cmd_decoder

- Register-command decoder directly downstream of the SPI slave in the IO expander.
- Consumes received bytes (`data_in` + `data_rdy`) and parses two-byte command frames.
- Maintains a small register file that drives the 8-bit output port, and returns read data to the SPI slave via `data_out`/`data_latch` so the master shifts it out on the next byte.
- All logic runs in the system clock domain; SPI-side strobes are synchronized here.

## Interface

Parameters:
- `SYNC_STAGES`, 2: synchronizer flops on `data_rdy` and `ss` (2 minimum).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ss`  in  1  SPI slave select, active-low, asynchronous to `clk`.
- `data_rdy`  in  1  byte-received strobe from the SPI slave, asynchronous. `data_in` is stable from its rise until the next byte completes.
- `data_in`  in  8  received byte.
- `data_out`  out  8  byte for the SPI slave to transmit next.
- `data_latch`  out  1  one-cycle pulse; SPI slave loads `data_out`.
- `out`  out  8  output port (OUT register).

## Operation

- Frame = command byte, then data byte.
  - Command bit7 = 1 means write, 0 means read.
  - Bits[2:0] = address. Bits[6:3] are ignored.
- Registers:
  - 0 OUT: read/write; drives `out`.
  - 1 TOGGLE: write only; OUT ^= data.
  - 2 SET: write only; OUT |= data.
  - 3 CLR: write only; OUT &= ~data.
  - 4 SCRATCH: read/write.
  - 5 STATUS: read only.
    - [7] err (sticky).
    - [6] abort (sticky).
    - [5:4] 0.
    - [3:0] frame_cnt.
  - 6, 7: unused.
- Reads of write-only or unused addresses return 0x00.
- FSM:
  - IDLE: a byte is taken as a command.
    - Read: load `data_out` with the register value, pulse `data_latch`, go to WAIT_DATA.
    - Write: store the address, go to WAIT_DATA.
  - WAIT_DATA: the next byte is data.
    - Write: apply it to the register.
    - Read: discard the byte.
    - Either way: frame_cnt += 1 (4-bit, wraps 15→0), go to IDLE.
- Write to address 5, 6 or 7: no register change, err ← 1, frame still counted.
- Read of STATUS: `data_out` captures STATUS first, then err and abort clear on the same cycle.
- Synchronized `ss` rising (deselect):
  - In WAIT_DATA: abort ← 1, go to IDLE, no register change, frame_cnt unchanged.
  - In IDLE: no effect.
- Same cycle as a byte edge, `ss` rise wins: the byte is discarded, and abort ← 1 if the state was WAIT_DATA.

## Timing

- `data_rdy` and `ss` each pass through `SYNC_STAGES` flops, then a previous-value flop for rising-edge detect.
- With `SYNC_STAGES` = 2, edge is detected at the 2nd `clk` edge after `data_rdy` rises and acted on at the 3rd:
  - `out` and register updates occur 3 `clk` edges after `data_rdy` rises.
  - `data_out` and `data_latch` occur 3 `clk` edges after `data_rdy` rises.
- `data_latch` is high exactly 1 cycle; `data_out` holds until the next read command.
- Consecutive `data_rdy` rises must be ≥ `SYNC_STAGES`+2 `clk` cycles apart; closer rises may merge (not detected).
- Reset values: state IDLE, `out` 0x00, SCRATCH 0x00, STATUS 0x00, `data_out` 0x00, `data_latch` 0, synchronizers 0.
- Reset asserted mid-frame: everything returns to reset values immediately. The first byte after release is a command.
- Synchronizer reset value 0, so a high `data_rdy` at reset release produces one edge.

## Structure

- Shared package holds:
  - address constants `ADDR_OUT` … `ADDR_STATUS`;
  - `CMD_WR_BIT` = 7;
  - address field width 3;
  - STATUS bit positions;
  - FSM state encoding (IDLE, WAIT_DATA).
- Sub-module `sync_rise`: `SYNC_STAGES`-flop synchronizer plus rising-edge pulse, async reset to 0. Instantiated twice (`data_rdy`, `ss`).
- Top module holds the FSM, register file, STATUS logic and readback mux.

## Test plan

- Write OUT: frame 0x80, 0x5A → `out` = 0x5A 3 clk after the 2nd `data_rdy`; frame_cnt = 1.
- SET/CLR/TOGGLE from `out` = 0x5A:
  - 0x82, 0x01 → 0x5B;
  - 0x83, 0x0A → 0x51;
  - 0x81, 0xFF → 0xAE.
- Readback: write SCRATCH 0xC3, then send 0x04 → `data_latch` pulses once, `data_out` = 0xC3; a dummy data byte leaves SCRATCH unchanged.
- Error: write 0x86, 0x11 → `out` unchanged; read STATUS returns 0x81 (err, frame_cnt = 1); a second STATUS read returns 0x02.
- Abort: 0x80 then `ss` high before the data byte → state IDLE, STATUS reads abort = 1, frame_cnt unchanged; a byte arriving in the same cycle as the `ss` rise is discarded.
- Reset mid-frame after 0x80 → `out` = 0x00; next 0x80, 0x33 sets `out` = 0x33. Also: 16 frames wrap frame_cnt to 0.

Source files
------------

// File: rtl/spi_cmd_decoder_pkg.sv
// Shared definitions for the SPI register-command decoder: field widths,
// register addresses, STATUS layout and FSM state encoding.
package spi_cmd_decoder_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned CNT_W  = 4;

    // Command byte layout: bit7 selects write, bits[2:0] carry the address.
    localparam int unsigned CMD_WR_BIT = 7;

    // Register map.
    localparam logic [ADDR_W-1:0] ADDR_OUT     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_TOGGLE  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_SET     = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CLR     = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_SCRATCH = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd5;

    // STATUS bit positions.
    localparam int unsigned STATUS_ERR_BIT   = 7;
    localparam int unsigned STATUS_ABORT_BIT = 6;
    localparam int unsigned STATUS_CNT_LSB   = 0;

    // STATUS register image as returned on readback.
    typedef struct packed {
        logic             err;
        logic             abort;
        logic [1:0]       rsvd;
        logic [CNT_W-1:0] frame_cnt;
    } status_t;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_DATA = 1'b1
    } state_t;

    // Assemble the STATUS image; reserved bits always read as zero.
    function automatic status_t pack_status(
        input logic             err,
        input logic             abort,
        input logic [CNT_W-1:0] frame_cnt
    );
        status_t s;
        s.err       = err;
        s.abort     = abort;
        s.rsvd      = 2'b00;
        s.frame_cnt = frame_cnt;
        return s;
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_sync.sv
// sync_rise: multi-flop synchronizer for an asynchronous level followed by
// a previous-value flop, producing a one-cycle pulse on each synchronized
// rising edge.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset (all flops clear to 0)
//   async_in   asynchronous input level
//   rise_c     combinational one-cycle rising-edge pulse (clk domain)
// SYNC_STAGES must be at least 2.
module sync_rise #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain plus one flop holding the prior synchronized value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Reset value 0 means an input already high at reset release yields one edge.
    assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: parses two-byte command frames (command, data) received
// from the SPI slave, maintains the OUT/SCRATCH/STATUS register file and
// returns read data to the SPI slave for transmission on the next byte.
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   ss          SPI slave select, active-low, asynchronous
//   data_rdy    byte-received strobe, asynchronous
//   data_in     received byte, stable from data_rdy rise to next byte
//   data_out    byte for the SPI slave to transmit next
//   data_latch  one-cycle pulse telling the SPI slave to load data_out
//   out         8-bit output port (OUT register)
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              data_rdy,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_latch,
    output logic [DATA_W-1:0] out
);

    logic byte_rise_c;
    logic ss_rise_c;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] scratch_q;
    logic              err_q;
    logic              abort_q;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic [DATA_W-1:0] data_out_q;
    logic              data_latch_q;

    logic [ADDR_W-1:0] cmd_addr_c;
    logic              cmd_wr_c;
    logic [DATA_W-1:0] rd_data_c;
    status_t           status_c;

    // Byte strobe and deselect edge detectors.
    sync_rise #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_rdy (
        .clk      (clk),
        .rst      (rst),
        .async_in (data_rdy),
        .rise_c   (byte_rise_c)
    );

    sync_rise #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_ss (
        .clk      (clk),
        .rst      (rst),
        .async_in (ss),
        .rise_c   (ss_rise_c)
    );

    assign cmd_addr_c = data_in[ADDR_W-1:0];
    assign cmd_wr_c   = data_in[CMD_WR_BIT];
    assign status_c   = pack_status(err_q, abort_q, frame_cnt_q);

    // Readback mux; write-only and unused addresses read as zero.
    always_comb begin
        rd_data_c = '0;
        case (cmd_addr_c)
            ADDR_OUT:     rd_data_c = out_q;
            ADDR_SCRATCH: rd_data_c = scratch_q;
            ADDR_STATUS:  rd_data_c = status_c;
            default:      rd_data_c = '0;
        endcase
    end

    // Frame FSM, register file and STATUS tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            out_q        <= '0;
            scratch_q    <= '0;
            err_q        <= 1'b0;
            abort_q      <= 1'b0;
            frame_cnt_q  <= '0;
            data_out_q   <= '0;
            data_latch_q <= 1'b0;
        end else begin
            data_latch_q <= 1'b0;
            // Deselect takes priority over a byte arriving in the same cycle.
            if (ss_rise_c) begin
                if (state_q == ST_WAIT_DATA) begin
                    abort_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            end else if (byte_rise_c) begin
                case (state_q)
                    ST_IDLE: begin
                        addr_q  <= cmd_addr_c;
                        wr_q    <= cmd_wr_c;
                        state_q <= ST_WAIT_DATA;
                        if (!cmd_wr_c) begin
                            data_out_q   <= rd_data_c;
                            data_latch_q <= 1'b1;
                            // STATUS is captured above before its sticky bits clear.
                            if (cmd_addr_c == ADDR_STATUS) begin
                                err_q   <= 1'b0;
                                abort_q <= 1'b0;
                            end
                        end
                    end
                    ST_WAIT_DATA: begin
                        if (wr_q) begin
                            case (addr_q)
                                ADDR_OUT:     out_q     <= data_in;
                                ADDR_TOGGLE:  out_q     <= out_q ^ data_in;
                                ADDR_SET:     out_q     <= out_q | data_in;
                                ADDR_CLR:     out_q     <= out_q & ~data_in;
                                ADDR_SCRATCH: scratch_q <= data_in;
                                default:      err_q     <= 1'b1;
                            endcase
                        end
                        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                        state_q     <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_latch = data_latch_q;
    assign out        = out_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Testbench for spi_cmd_decoder: directed register-map scenarios followed
// by randomized frames, all checked against a frame-level reference model.
module tb_spi_cmd_decoder;

    logic       clk;
    logic       rst;
    logic       ss;
    logic       data_rdy;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_latch;
    logic [7:0] out_port;

    int n_vec;
    int n_miss;

    // Reference model state: register contents and whether a frame is open.
    logic [7:0] m_out;
    logic [7:0] m_scratch;
    logic       m_err;
    logic       m_abort;
    int         m_cnt;
    logic [7:0] m_dout;
    logic       m_in_frame;
    logic [7:0] m_cmd;
    logic       m_latch;

    spi_cmd_decoder #(
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ss         (ss),
        .data_rdy   (data_rdy),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_latch (data_latch),
        .out        (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out      = 8'h00;
        m_scratch  = 8'h00;
        m_err      = 1'b0;
        m_abort    = 1'b0;
        m_cnt      = 0;
        m_dout     = 8'h00;
        m_in_frame = 1'b0;
        m_cmd      = 8'h00;
        m_latch    = 1'b0;
    endtask

    function automatic logic [7:0] model_status();
        return 8'((m_err ? 128 : 0) + (m_abort ? 64 : 0) + m_cnt);
    endfunction

    function automatic logic [7:0] model_read(input int addr);
        case (addr)
            0:       return m_out;
            4:       return m_scratch;
            5:       return model_status();
            default: return 8'h00;
        endcase
    endfunction

    // Apply one received byte to the model at frame level.
    task automatic model_byte(input logic [7:0] b);
        int addr;
        m_latch = 1'b0;
        if (!m_in_frame) begin
            m_cmd = b;
            addr  = int'(b % 8);
            if (b < 8'h80) begin
                m_dout  = model_read(addr);
                m_latch = 1'b1;
                if (addr == 5) begin
                    m_err   = 1'b0;
                    m_abort = 1'b0;
                end
            end
            m_in_frame = 1'b1;
        end else begin
            addr = int'(m_cmd % 8);
            if (m_cmd >= 8'h80) begin
                case (addr)
                    0:       m_out = b;
                    1:       m_out = m_out ^ b;
                    2:       m_out = m_out | b;
                    3:       m_out = m_out & ~b;
                    4:       m_scratch = b;
                    default: m_err = 1'b1;
                endcase
            end
            m_cnt      = (m_cnt + 1) % 16;
            m_in_frame = 1'b0;
        end
    endtask

    task automatic check_outputs(input logic exp_latch);
        check_eq("out", out_port, m_out);
        check_eq("data_out", data_out, m_dout);
        check_eq("data_latch", {7'b0, data_latch}, {7'b0, exp_latch});
    endtask

    // Deliver a byte; outputs are checked 3 clk edges after the data_rdy rise.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data_in  = b;
        data_rdy = 1'b1;
        model_byte(b);
        repeat (3) @(posedge clk);
        #1;
        check_outputs(m_latch);
        @(negedge clk);
        data_rdy = 1'b0;
        @(posedge clk);
        #1;
        check_eq("latch_pulse_end", {7'b0, data_latch}, 8'h00);
        repeat (2) @(posedge clk);
    endtask

    // Raise ss, optionally together with a byte strobe that must be discarded.
    task automatic deselect(input logic with_byte, input logic [7:0] b);
        @(negedge clk);
        ss = 1'b1;
        if (with_byte) begin
            data_in  = b;
            data_rdy = 1'b1;
        end
        if (m_in_frame) begin
            m_abort    = 1'b1;
            m_in_frame = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_outputs(1'b0);
        @(negedge clk);
        ss       = 1'b0;
        data_rdy = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("rst_out", out_port, 8'h00);
        check_eq("rst_data_out", data_out, 8'h00);
        check_eq("rst_latch", {7'b0, data_latch}, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        ss       = 1'b0;
        data_rdy = 1'b0;
        data_in  = 8'h00;
        rst      = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_out", out_port, 8'h00);
        check_eq("reset_data_out", data_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Write OUT, then SET / CLR / TOGGLE.
        send_byte(8'h80); send_byte(8'h5A);
        check_eq("wr_out", out_port, 8'h5A);
        send_byte(8'h82); send_byte(8'h01);
        check_eq("set", out_port, 8'h5B);
        send_byte(8'h83); send_byte(8'h0A);
        check_eq("clr", out_port, 8'h51);
        send_byte(8'h81); send_byte(8'hFF);
        check_eq("toggle", out_port, 8'hAE);

        // SCRATCH readback; dummy byte must not modify it.
        send_byte(8'h84); send_byte(8'hC3);
        send_byte(8'h04);
        check_eq("rd_scratch", data_out, 8'hC3);
        send_byte(8'h99);
        send_byte(8'h04);
        check_eq("rd_scratch_again", data_out, 8'hC3);
        send_byte(8'h00);

        // Write to a read-only address sets err; STATUS read clears it.
        apply_reset();
        send_byte(8'h86); send_byte(8'h11);
        check_eq("err_out_unchanged", out_port, 8'h00);
        send_byte(8'h05);
        check_eq("status_err", data_out, 8'h81);
        send_byte(8'h00);
        send_byte(8'h05);
        check_eq("status_cleared", data_out, 8'h02);
        send_byte(8'h00);

        // Deselect mid-frame aborts; a simultaneous byte is discarded.
        apply_reset();
        send_byte(8'h80);
        deselect(1'b0, 8'h00);
        send_byte(8'h05);
        check_eq("status_abort", data_out, 8'h40);
        send_byte(8'h00);
        send_byte(8'h80);
        deselect(1'b1, 8'h77);
        check_eq("abort_out_unchanged", out_port, 8'h00);
        send_byte(8'h05);
        check_eq("status_abort2", data_out, 8'h41);
        send_byte(8'h00);
        deselect(1'b1, 8'h80);
        send_byte(8'h80); send_byte(8'h3C);
        check_eq("idle_deselect_noop", out_port, 8'h3C);

        // Reset in the middle of a frame.
        send_byte(8'h80); send_byte(8'hFF);
        send_byte(8'h80);
        apply_reset();
        send_byte(8'h80); send_byte(8'h33);
        check_eq("post_reset_write", out_port, 8'h33);

        // frame_cnt wraps after 16 frames.
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h84);
            send_byte(8'(i));
        end
        send_byte(8'h05);
        check_eq("cnt_wrap", data_out, 8'h00);
        send_byte(8'h00);

        // Randomized frames with occasional aborts.
        for (int i = 0; i < 150; i++) begin
            logic [7:0] cmd;
            cmd = 8'($urandom);
            send_byte(cmd);
            if ($urandom_range(0, 9) == 0)
                deselect(1'($urandom_range(0, 1)), 8'($urandom));
            else
                send_byte(8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
